ram_bist_controller: RTL and testbench

- Initiator-side companion to the 8-bit RAM: drives address, write enable and write data into the RAM, and reads the RAM data output back.
- On a start pulse it writes a deterministic pattern to every location, reads each location back and compares it.
- Reports busy, done, pass, a mismatch count and the first failing address.
- Sits between the top-level test/control logic and the RAM, replacing bench-driven stimulus on those RAM ports.

---
 rtl/ram_bist_controller_pkg.sv | 23 ++
 rtl/bist_pattern_gen.sv | 16 +
 rtl/ram_bist_controller.sv | 182 ++++++++++++++++++
 tb/tb_ram_bist_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_controller_pkg.sv
// Shared definitions for the RAM BIST controller: FSM states, default seed
// and the address-to-pattern rule used for both writing and checking.
package ram_bist_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } bist_state_e;

   localparam logic [7:0] DEFAULT_SEED = 8'hA5;

   // Wide enough for any practical address/data width; callers truncate.
   localparam int PAT_W = 64;

   function automatic logic [PAT_W-1:0] bist_pattern(input logic [PAT_W-1:0] addr,
                                                     input logic [PAT_W-1:0] seed);
      return addr ^ seed;
   endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// Combinational address-to-pattern generator: pattern(a) = a[DATA_WIDTH-1:0] ^ SEED.
// Kept standalone so a RAM preload block can reuse the same rule.
module bist_pattern_gen
   import ram_bist_controller_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(DEFAULT_SEED)
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [DATA_WIDTH-1:0] pattern_o
);

   assign pattern_o = DATA_WIDTH'(bist_pattern(PAT_W'(addr_i), PAT_W'(SEED)));

endmodule

// File: rtl/ram_bist_controller.sv
// March-free write-then-verify BIST for a single-port RAM: writes pattern(a) to
// every location, reads each back after READ_LATENCY+1 cycles and tallies mismatches.
module ram_bist_controller
   import ram_bist_controller_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    ADDR_WIDTH   = 8,
   parameter int                    DEPTH        = 32,
   parameter int                    READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] SEED         = DATA_WIDTH'(DEFAULT_SEED),
   localparam int                   ERR_W        = $clog2(DEPTH + 1)
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] ramAddress,
   output logic                  ramWE,
   output logic [DATA_WIDTH-1:0] ramDataIn,
   input  logic [DATA_WIDTH-1:0] ramDataOut,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      errorCount,
   output logic [ADDR_WIDTH-1:0] firstFailAddr
);

   localparam int                    WAIT_W    = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
   localparam logic [WAIT_W-1:0]     LAST_WAIT = WAIT_W'(READ_LATENCY);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ERR_W-1:0]      ERR_MAX   = ERR_W'(DEPTH);

   bist_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
   logic [WAIT_W-1:0]     wait_q,  wait_d;
   logic                  we_q,    we_d;
   logic [DATA_WIDTH-1:0] din_q,   din_d;
   logic                  busy_q,  busy_d;
   logic                  done_q,  done_d;
   logic                  pass_q,  pass_d;
   logic [ERR_W-1:0]      err_q,   err_d;
   logic [ADDR_WIDTH-1:0] ffa_q,   ffa_d;

   logic [ADDR_WIDTH-1:0] addr_inc;
   logic [ADDR_WIDTH-1:0] wr_addr_nxt;
   logic [DATA_WIDTH-1:0] wr_pattern;
   logic [DATA_WIDTH-1:0] chk_pattern;
   logic                  mismatch;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
      return (cnt == ERR_MAX) ? cnt : cnt + ERR_W'(1);
   endfunction

   // Write data is registered, so the pattern is generated for the address of the next cycle.
   assign addr_inc    = addr_q + ADDR_WIDTH'(1);
   assign wr_addr_nxt = (state_q == ST_WRITE) ? addr_inc : '0;

   bist_pattern_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .SEED       (SEED)
   ) u_wr_pattern (
      .addr_i    (wr_addr_nxt),
      .pattern_o (wr_pattern)
   );

   bist_pattern_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .SEED       (SEED)
   ) u_chk_pattern (
      .addr_i    (addr_q),
      .pattern_o (chk_pattern)
   );

   assign mismatch = (ramDataOut != chk_pattern);

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wait_q  <= '0;
         we_q    <= 1'b0;
         din_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ffa_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wait_q  <= wait_d;
         we_q    <= we_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         ffa_q   <= ffa_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wait_d  = wait_q;
      we_d    = 1'b0;
      din_d   = '0;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      ffa_d   = ffa_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_WRITE;
               addr_d  = '0;
               wait_d  = '0;
               we_d    = 1'b1;
               din_d   = wr_pattern;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
               ffa_d   = '0;
            end
         end

         ST_WRITE: begin
            if (addr_q == LAST_ADDR) begin
               state_d = ST_READ;
               addr_d  = '0;
               wait_d  = '0;
            end else begin
               addr_d = addr_inc;
               we_d   = 1'b1;
               din_d  = wr_pattern;
            end
         end

         // The check happens on the same edge that samples the last wait cycle.
         ST_READ: begin
            if (wait_q == LAST_WAIT) begin
               wait_d = '0;
               if (mismatch) begin
                  err_d = sat_inc(err_q);
                  if (err_q == '0) begin
                     ffa_d = addr_q;
                  end
               end
               if (addr_q == LAST_ADDR) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == '0);
               end else begin
                  addr_d = addr_inc;
               end
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign ramAddress    = addr_q;
   assign ramWE         = we_q;
   assign ramDataIn     = din_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign errorCount    = err_q;
   assign firstFailAddr = ffa_q;

endmodule

// File: tb/tb_ram_bist_controller.sv
// Bench for ram_bist_controller: behavioural RAMs with injectable stuck-at faults,
// expected results computed from the pattern rule over the whole address range.
module tb_ram_bist_controller;

   logic clock = 1'b0;
   logic resetN;
   always #5 clock = ~clock;

   // Default instance: DEPTH=32, READ_LATENCY=1
   logic       startA, weA, busyA, doneA, passA;
   logic [7:0] addrA, dinA, doutA, ffaA;
   logic [5:0] errA;

   // Small instance: DEPTH=4, READ_LATENCY=3
   logic       startB, weB, busyB, doneB, passB;
   logic [7:0] addrB, dinB, doutB, ffaB;
   logic [2:0] errB;

   ram_bist_controller dutA (
      .clock(clock), .resetN(resetN), .start(startA),
      .ramAddress(addrA), .ramWE(weA), .ramDataIn(dinA), .ramDataOut(doutA),
      .busy(busyA), .done(doneA), .pass(passA), .errorCount(errA), .firstFailAddr(ffaA)
   );

   ram_bist_controller #(.DEPTH(4), .READ_LATENCY(3)) dutB (
      .clock(clock), .resetN(resetN), .start(startB),
      .ramAddress(addrB), .ramWE(weB), .ramDataIn(dinB), .ramDataOut(doutB),
      .busy(busyB), .done(doneB), .pass(passB), .errorCount(errB), .firstFailAddr(ffaB)
   );

   // Fault injection on RAM A read data
   logic       f_en, f_all, f_val;
   logic [7:0] f_addr;
   int         f_bit;

   logic [7:0] memA [0:255];
   logic [7:0] raddrA_q;
   always @(posedge clock) begin
      if (weA) memA[addrA] <= dinA;
      raddrA_q <= addrA;
   end
   always_comb begin
      doutA = memA[raddrA_q];
      if (f_en && (f_all || raddrA_q == f_addr)) doutA[f_bit] = f_val;
   end

   logic [7:0] memB [0:255];
   logic [7:0] rB1, rB2, rB3;
   always @(posedge clock) begin
      if (weB) memB[addrB] <= dinB;
      rB1 <= addrB;
      rB2 <= rB1;
      rB3 <= rB2;
   end
   assign doutB = memB[rB3];

   // Write log of instance A
   logic [7:0] wlog_addr[$];
   logic [7:0] wlog_data[$];
   always @(posedge clock) begin
      if (weA) begin
         wlog_addr.push_back(addrA);
         wlog_data.push_back(dinA);
      end
   end

   int checks = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: count locations whose read-back (pattern with the fault applied) differs.
   task automatic model(input int depth, output int cnt, output int ffa);
      logic [7:0] p, r;
      cnt = 0;
      ffa = 0;
      for (int a = 0; a < depth; a++) begin
         p = 8'(a) ^ 8'hA5;
         r = p;
         if (f_en && (f_all || a == int'(f_addr))) r[f_bit] = f_val;
         if (r != p) begin
            if (cnt == 0) ffa = a;
            cnt++;
         end
      end
   endtask

   task automatic run_a(input int pulse_at, output int cycles);
      wlog_addr.delete();
      wlog_data.delete();
      @(posedge clock); #1;
      startA = 1'b1;
      @(posedge clock); #1;
      startA = 1'b0;
      cycles = 0;
      check("start_busy", 32'(busyA), 32'd1);
      check("start_clears_done", 32'(doneA), 32'd0);
      while (!doneA && cycles < 400) begin
         startA = (cycles == pulse_at);
         @(posedge clock); #1;
         startA = 1'b0;
         cycles++;
      end
   endtask

   task automatic run_fault_case(input string tag);
      int cyc, exp_cnt, exp_ffa;
      model(32, exp_cnt, exp_ffa);
      run_a(-1, cyc);
      check({tag, "_latency"}, 32'(cyc), 32'd96);
      check({tag, "_err"}, 32'(errA), 32'(exp_cnt));
      check({tag, "_ffa"}, 32'(ffaA), 32'(exp_ffa));
      check({tag, "_pass"}, 32'(passA), 32'(exp_cnt == 0));
   endtask

   initial begin
      int cyc, bad, k, holdbad, idle;
      resetN = 1'b0; startA = 1'b0; startB = 1'b0;
      f_en = 1'b0; f_all = 1'b0; f_val = 1'b0; f_addr = 8'd0; f_bit = 0;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_we", 32'(weA), 32'd0);
      check("rst_addr", 32'(addrA), 32'd0);
      check("rst_din", 32'(dinA), 32'd0);
      check("rst_busy", 32'(busyA), 32'd0);
      check("rst_done", 32'(doneA), 32'd0);
      check("rst_pass", 32'(passA), 32'd0);
      check("rst_err", 32'(errA), 32'd0);
      check("rst_ffa", 32'(ffaA), 32'd0);
      check("rst_busyB", 32'(busyB), 32'd0);
      resetN = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // Fault-free run with the write sequence inspected
      run_a(-1, cyc);
      check("clean_latency", 32'(cyc), 32'd96);
      check("clean_pass", 32'(passA), 32'd1);
      check("clean_err", 32'(errA), 32'd0);
      check("clean_ffa", 32'(ffaA), 32'd0);
      check("clean_busy_done", 32'(busyA), 32'd0);
      check("wr_count", 32'(wlog_addr.size()), 32'd32);
      bad = 0;
      for (int i = 0; i < wlog_addr.size(); i++)
         if (wlog_addr[i] != 8'(i) || wlog_data[i] != (8'(i) ^ 8'hA5)) bad++;
      check("wr_sequence", 32'(bad), 32'd0);
      if (wlog_data.size() == 32) begin
         check("wr_first_data", 32'(wlog_data[0]), 32'hA5);
         check("wr_last_data", 32'(wlog_data[31]), 32'hBA);
      end

      // Outputs held in DONE
      repeat (5) @(posedge clock);
      #1;
      check("done_held", 32'(doneA), 32'd1);
      check("done_we_low", 32'(weA), 32'd0);

      // Stuck-at-0 on bit 3 at address 13
      f_en = 1'b1; f_all = 1'b0; f_addr = 8'd13; f_bit = 3; f_val = 1'b0;
      run_fault_case("stuck13");

      // Bit 0 stuck-at-1 everywhere
      f_all = 1'b1; f_bit = 0; f_val = 1'b1;
      run_fault_case("bit0_sa1");

      // start while busy is ignored
      f_en = 1'b0;
      run_a(20, cyc);
      check("restart_latency", 32'(cyc), 32'd96);
      check("restart_pass", 32'(passA), 32'd1);
      check("restart_err", 32'(errA), 32'd0);

      // Reset during the write phase at address 10
      @(posedge clock); #1;
      startA = 1'b1;
      @(posedge clock); #1;
      startA = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      check("pre_rst_addr", 32'(addrA), 32'd10);
      check("pre_rst_we", 32'(weA), 32'd1);
      resetN = 1'b0;
      @(posedge clock); #1;
      resetN = 1'b1;
      check("abort_we", 32'(weA), 32'd0);
      check("abort_busy", 32'(busyA), 32'd0);
      check("abort_addr", 32'(addrA), 32'd0);
      check("abort_din", 32'(dinA), 32'd0);
      check("abort_done", 32'(doneA), 32'd0);
      // Idle must stay idle after the abort
      repeat (3) @(posedge clock);
      #1;
      check("abort_idle_we", 32'(weA), 32'd0);
      run_a(-1, cyc);
      check("after_abort_latency", 32'(cyc), 32'd96);
      check("after_abort_pass", 32'(passA), 32'd1);

      // Randomized single-bit faults
      for (int it = 0; it < 4; it++) begin
         f_en   = 1'b1;
         f_all  = 1'($urandom_range(0, 1));
         f_addr = 8'($urandom_range(0, 31));
         f_bit  = int'($urandom_range(0, 7));
         f_val  = 1'($urandom_range(0, 1));
         idle   = int'($urandom_range(0, 5));
         repeat (idle) @(posedge clock);
         #1;
         run_fault_case($sformatf("rand%0d", it));
      end
      f_en = 1'b0;

      // DEPTH=4, READ_LATENCY=3 instance
      @(posedge clock); #1;
      startB = 1'b1;
      @(posedge clock); #1;
      startB = 1'b0;
      k = 0;
      holdbad = 0;
      while (!doneB && k < 200) begin
         if (k < 4) begin
            if (addrB != 8'(k) || weB != 1'b1) holdbad++;
         end else if (k < 20) begin
            if (addrB != 8'((k - 4) / 4) || weB != 1'b0) holdbad++;
         end
         @(posedge clock); #1;
         k++;
      end
      check("B_latency", 32'(k), 32'd20);
      check("B_addr_hold", 32'(holdbad), 32'd0);
      check("B_pass", 32'(passB), 32'd1);
      check("B_err", 32'(errB), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
